// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch stage with PC, credit-limited requests and instruction buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t         state;
    logic [31:0]    pc;
    logic [31:0]    fifo_data [FIFO_DEPTH];
    logic [31:0]    fifo_pc   [FIFO_DEPTH];
    logic [31:0]    tag_q     [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr, tag_wr, tag_rd;
    logic [CW-1:0]  fifo_count, outstanding, drop_cnt, outstanding_nxt;
    logic [CW:0]    credit_used;
    logic           accept, push, pop;

    // Outstanding requests plus buffered words never exceed the buffer depth,
    // so every response always has a free slot and needs no backpressure.
    assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid  = rst_n && (state == RUN) && (credit_used < DEPTH_C) && !redirect_valid;
    assign imem_addr       = pc;
    assign accept          = imem_req_valid && imem_req_ready;
    assign instr_valid     = (fifo_count != '0) && (state == RUN);
    assign instr           = fifo_data[rd_ptr];
    assign instr_pc        = fifo_pc[rd_ptr];
    assign pop             = instr_valid && instr_ready;
    assign push            = imem_resp_valid && (state == RUN);
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_resp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC & PC_MASK;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
                tag_q[i]     <= '0;
            end
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // Every request still in flight, including one answered this
                // cycle, belongs to the old path and must be discarded.
                pc         <= redirect_pc & PC_MASK;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                tag_wr     <= '0;
                tag_rd     <= '0;
                fifo_count <= '0;
                drop_cnt   <= outstanding_nxt;
                state      <= (outstanding_nxt != '0) ? FLUSH : RUN;
            end else begin
                if (accept) begin
                    pc            <= pc + 32'd4;
                    tag_q[tag_wr] <= pc;
                    tag_wr        <= tag_wr + 1'b1;
                end
                if (push) begin
                    fifo_data[wr_ptr] <= imem_resp_data;
                    fifo_pc[wr_ptr]   <= tag_q[tag_rd];
                    tag_rd            <= tag_rd + 1'b1;
                    wr_ptr            <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if ((state == FLUSH) && imem_resp_valid) begin
                    drop_cnt <= drop_cnt - 1'b1;
                    if (drop_cnt == CW'(1)) begin
                        state <= RUN;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [31:0] imem_addr, imem_resp_data = '0;
    logic        redirect_valid, instr_valid, instr_ready;
    logic [31:0] redirect_pc, instr, instr_pc;

    logic        rst_n_w, req_valid_w, req_ready_w, resp_valid_w = 1'b0;
    logic [31:0] addr_w, resp_data_w = '0;
    logic        redirect_valid_w, instr_valid_w, instr_ready_w;
    logic [31:0] redirect_pc_w, instr_w, instr_pc_w;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .rst_n(rst_n_w),
        .imem_req_valid(req_valid_w), .imem_req_ready(req_ready_w), .imem_addr(addr_w),
        .imem_resp_valid(resp_valid_w), .imem_resp_data(resp_data_w),
        .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready_w), .instr(instr_w), .instr_pc(instr_pc_w)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    logic [31:0] req_addr[$], got_pc[$], got_word[$], rsp_addr[$];
    int          req_cyc[$], rsp_due[$];
    logic [31:0] req_log_w[$], got_w[$];
    logic        pend_w = 1'b0;
    logic [31:0] pend_addr_w = '0;

    // Memory model: in-order responses returning addr ^ 0x13 after lat cycles.
    always @(posedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            req_addr.push_back(imem_addr);
            req_cyc.push_back(cyc);
            rsp_addr.push_back(imem_addr);
            rsp_due.push_back(cyc + lat);
        end
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            got_pc.push_back(instr_pc);
            got_word.push_back(instr);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_addr.delete();
            rsp_due.delete();
            imem_resp_valid = 1'b0;
        end else if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = rsp_addr.pop_front() ^ 32'h0000_0013;
            void'(rsp_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
        end
    end

    always @(posedge clk) begin
        pend_w      = rst_n_w && req_valid_w && req_ready_w;
        pend_addr_w = addr_w;
        if (pend_w && req_log_w.size() < 8) req_log_w.push_back(addr_w);
        if (rst_n_w && instr_valid_w && instr_ready_w && got_w.size() < 8) got_w.push_back(instr_pc_w);
    end

    always @(negedge clk) begin
        resp_valid_w = pend_w;
        resp_data_w  = pend_addr_w ^ 32'h0000_0013;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int base, g, rd_cyc, d;

    initial begin
        rst_n = 1'b0; rst_n_w = 1'b0;
        imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        req_ready_w = 1'b1; instr_ready_w = 1'b1;
        redirect_valid_w = 1'b0; redirect_pc_w = '0;

        // Reset values and straight-line fetch
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        end
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        rst_n = 1'b1; rst_n_w = 1'b1;
        for (int i = 0; i < 40 && got_pc.size() < 4; i++) tick();
        for (int i = 0; i < 4; i++) begin
            check("seq_pc", qget(got_pc, i), 32'(4 * i));
            check("seq_word", qget(got_word, i), 32'(4 * i) ^ 32'h13);
        end

        // RESET_PC near the top of the address space wraps to 0
        for (int i = 0; i < 40 && got_w.size() < 3; i++) tick();
        check("wrap_req0", qget(req_log_w, 0), 32'hFFFF_FFF8);
        check("wrap_req1", qget(req_log_w, 1), 32'hFFFF_FFFC);
        check("wrap_req2", qget(req_log_w, 2), 32'h0000_0000);
        check("wrap_pc0", qget(got_w, 0), 32'hFFFF_FFF8);
        check("wrap_pc2", qget(got_w, 2), 32'h0000_0000);

        // Decode stall: credit limit stops requests at the buffer depth
        instr_ready = 1'b0;
        lat = 1;
        base = req_addr.size();
        do_reset();
        repeat (10) tick();
        check("stall_reqs", 32'(req_addr.size() - base), 32'd2);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        check("stall_head_pc", instr_pc, 32'h0);
        g = got_pc.size();
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && (got_pc.size() < g + 2 || req_addr.size() < base + 3); i++) tick();
        check("stall_pop0", qget(got_pc, g), 32'h0);
        check("stall_pop1", qget(got_pc, g + 1), 32'h4);
        check("stall_resume", qget(req_addr, base + 2), 32'h8);

        // Redirect with two stale requests in flight
        lat = 3;
        base = req_addr.size();
        do_reset();
        for (int i = 0; i < 20 && req_addr.size() < base + 2; i++) tick();
        g = got_pc.size();
        rd_cyc = cyc;
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        base = req_addr.size();
        for (int i = 0; i < 30 && (req_addr.size() <= base || got_pc.size() <= g); i++) tick();
        check("flush_req", qget(req_addr, base), 32'h100);
        d = (req_cyc.size() > base) ? req_cyc[base] - rd_cyc : -1;
        check("flush_gap", 32'(d), 32'd3);
        check("flush_first_pc", qget(got_pc, g), 32'h100);
        check("flush_first_word", qget(got_word, g), 32'h113);

        // Redirect coinciding with a response and a decode pop
        lat = 1;
        do_reset();
        for (int i = 0; i < 20 && !(imem_resp_valid && instr_valid); i++) tick();
        check("coinc_setup", {31'b0, imem_resp_valid && instr_valid}, 32'd1);
        g = got_pc.size();
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        check("coinc_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("coinc_addr", imem_addr, 32'h200);
        check("coinc_no_pop", 32'(got_pc.size() - g), 32'd0);
        for (int i = 0; i < 20 && got_pc.size() <= g; i++) tick();
        check("coinc_pc", qget(got_pc, g), 32'h200);
        check("coinc_word", qget(got_word, g), 32'h213);

        // Asynchronous reset with work in flight
        lat = 3;
        instr_ready = 1'b0;
        base = req_addr.size();
        do_reset();
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check("areset_pre_instr", instr, 32'h13);
        check("areset_pre_out", 32'(req_addr.size() - base), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("areset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("areset_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("areset_instr", instr, 32'd0);
        check("areset_instr_pc", instr_pc, 32'd0);
        check("areset_addr", imem_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        base = req_addr.size();
        for (int i = 0; i < 20 && req_addr.size() <= base; i++) tick();
        check("areset_first_req", qget(req_addr, base), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
